lazer_marker_overlay: RTL and testbench
=======================================

Name: lazer_marker_overlay

Overview:
- Consumer side of the laser locator: takes the packed laser_xy result and redraws it into the pixel stream as a crosshair marker for the video output path.
- Sits downstream of the laser detector, on the same x/y/data/en pixel stream.
- Double-buffers the coordinate at frame start so the marker never tears mid-frame.
- Hides the marker when the coordinate goes stale.

Parameters:
- ARM_LEN, 8: crosshair half-length in pixels, inclusive.
- GAP, 2: central hole radius in pixels; pixels with distance < GAP are not drawn.
- STALE_FRAMES, 4: the marker is hidden once this many consecutive frame starts pass without a laser_valid.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- en  in  1  pixel-valid qualifier for x/y/data.
- x  in  32  pixel column; bits [15:0] used.
- y  in  32  pixel row; bits [15:0] used.
- data  in  `PIXEL_SIZE (24)  pixel in, {R[23:16], B[15:8], G[7:0]}.
- laser_xy  in  32  {laser_x[15:0], laser_y[15:0]} from the detector.
- laser_valid  in  1  laser_xy holds a fresh detection this cycle.
- overlay_en  in  1  global marker enable; 0 = pure pass-through.
- marker_color  in  24  replacement pixel value for marker pixels.
- out_data  out  24  pixel out.
- out_x  out  32  x delayed to align with out_data.
- out_y  out  32  y delayed to align with out_data.
- out_en  out  1  en delayed to align with out_data.

Behaviour:
- Reset (reset_n low at a clk edge):
  - All outputs 0.
  - pending_xy, active_xy = 0.
  - seen = 0.
  - stale_cnt = STALE_FRAMES, so the marker is off until the first detection.
- Pipeline: fixed latency of 2 cycles, free-running, no stall.
  - Stage 1 registers x, y, data and en unconditionally.
  - Stage 2 registers the outputs.
  - out_en(N+2) = en(N); data and coordinates pass through even when en = 0.
- Capture:
  - When laser_valid = 1, pending_xy <= laser_xy and seen <= 1.
  - laser_valid is independent of en.
- Frame start is the cycle with en = 1, x = 0 and y = 0.
  - active_xy <= (laser_valid ? laser_xy : pending_xy). The incoming value bypasses pending.
  - stale_cnt <= 0 if (seen or laser_valid); otherwise stale_cnt + 1, saturating at STALE_FRAMES.
  - seen <= 0 that cycle.
  - A laser_valid on the frame-start cycle counts for the frame now starting.
- active_xy and stale_cnt change only at frame start.
- Stage 1 registers the frame-start pixel in the same cycle that active_xy updates, so stage 2 evaluates pixel (0,0) against the new active_xy.
- Marker test in stage 2, on the registered coordinates:
  - Inputs: xs = x_s1[15:0], ys = y_s1[15:0], lx = active_xy[31:16], ly = active_xy[15:0].
  - Form dx = |xs − lx| and dy = |ys − ly| as 16-bit unsigned absolute differences. No wrap: compute in 17-bit signed, then take magnitude.
  - hit = (ys == ly && GAP <= dx <= ARM_LEN) || (xs == lx && GAP <= dy <= ARM_LEN).
  - out_data = (overlay_en_s1 && en_s1 && stale_cnt < STALE_FRAMES && hit) ? marker_color : data_s1.
  - overlay_en is registered in stage 1 with the pixel.
- Edges: a marker near the image border is simply clipped; no wrap across rows or columns.
- The marker is off when stale_cnt == STALE_FRAMES. A single valid frame re-enables it from the next frame start.
- en deasserted mid-frame: no state change. Frame start requires en = 1.
- Reset mid-frame: takes effect on the next edge. The pipeline is flushed to 0 and the marker stays off until a new detection plus a frame start.

Test Plan:
- Reset, then stream a 32x16 frame with no laser_valid -> out_data == data at every pixel; out_en, out_x, out_y equal the inputs delayed by exactly 2 cycles.
- laser_xy = {16'd10, 16'd5} with laser_valid pulsed mid-frame 0, then frame 1 streamed (ARM_LEN=8, GAP=2) -> in frame 1, marker_color at (2..8,5), (12..18,5), (10,0..3) and (10,7..13); (10,5), (9,5), (11,5) and (19,5) pass through. Frame 0 is untouched.
- laser_valid with a new xy mid-frame 1 -> frame 1 marker stays at the old position and moves only in frame 2.
- laser_valid asserted on the (0,0) frame-start cycle with xy = {16'd0, 16'd0} -> marker drawn in that same frame at (2..8,0) and (0,2..8).
- One detection, then 4 frame starts with no laser_valid (STALE_FRAMES=4) -> marker present in the first 4 frames after capture and absent in frame 5. A new laser_valid restores it at the next frame start.
- overlay_en = 0 with a valid marker, and separately reset_n pulsed mid-frame -> pure pass-through; after the reset, outputs are 0 for 2 cycles and no marker appears until a fresh laser_valid plus a frame start.

Source files
------------

// File: rtl/lazer_marker_overlay.sv
// Crosshair overlay for the laser locator result on the x/y/data/en stream.
// Ports: clk, reset_n, en/x/y/data in, laser_xy/laser_valid, overlay_en,
//   marker_color; out_data/out_x/out_y/out_en aligned 2 cycles later.
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif

module lazer_marker_overlay #(
  parameter int ARM_LEN      = 8,
  parameter int GAP          = 2,
  parameter int STALE_FRAMES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [31:0]            x,
  input  logic [31:0]            y,
  input  logic [`PIXEL_SIZE-1:0] data,
  input  logic [31:0]            laser_xy,
  input  logic                   laser_valid,
  input  logic                   overlay_en,
  input  logic [`PIXEL_SIZE-1:0] marker_color,
  output logic [`PIXEL_SIZE-1:0] out_data,
  output logic [31:0]            out_x,
  output logic [31:0]            out_y,
  output logic                   out_en
);

  localparam int PW = `PIXEL_SIZE;
  localparam int SW = $clog2(STALE_FRAMES + 1);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_FRAMES);
  localparam logic [15:0]   GAP_W     = 16'(GAP);
  localparam logic [15:0]   ARM_W     = 16'(ARM_LEN);

  typedef struct packed {
    logic          en;
    logic          ov;
    logic [31:0]   x;
    logic [31:0]   y;
    logic [PW-1:0] data;
  } s1_t;

  s1_t            s1;
  logic [31:0]    pending_xy;
  logic [31:0]    active_xy;
  logic           seen;
  logic [SW-1:0]  stale_cnt;
  logic [SW-1:0]  stale_nxt;
  logic           frame_start;

  logic signed [16:0] diff_x;
  logic signed [16:0] diff_y;
  logic signed [16:0] neg_x;
  logic signed [16:0] neg_y;
  logic [15:0]        dx;
  logic [15:0]        dy;
  logic               hit_row;
  logic               hit_col;
  logic               show;

  assign frame_start = en && (x[15:0] == 16'd0)
                          && (y[15:0] == 16'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= '0;
    end else begin
      s1.en   <= en;
      s1.ov   <= overlay_en;
      s1.x    <= x;
      s1.y    <= y;
      s1.data <= data;
    end
  end

  // Saturating count of frame starts without any detection.
  always_comb begin
    stale_nxt = stale_cnt;
    if (seen || laser_valid)
      stale_nxt = '0;
    else if (stale_cnt != STALE_MAX)
      stale_nxt = stale_cnt + SW'(1);
  end

  // A detection on the frame-start cycle bypasses pending
  // and counts for the frame now starting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_xy <= '0;
      active_xy  <= '0;
      seen       <= 1'b0;
      stale_cnt  <= STALE_MAX;
    end else begin
      if (laser_valid)
        pending_xy <= laser_xy;
      if (frame_start) begin
        active_xy <= laser_valid ? laser_xy : pending_xy;
        stale_cnt <= stale_nxt;
        seen      <= 1'b0;
      end else if (laser_valid) begin
        seen <= 1'b1;
      end
    end
  end

  // Distances in 17-bit signed so border markers clip, never wrap.
  always_comb begin
    diff_x  = $signed({1'b0, s1.x[15:0]})
            - $signed({1'b0, active_xy[31:16]});
    diff_y  = $signed({1'b0, s1.y[15:0]})
            - $signed({1'b0, active_xy[15:0]});
    neg_x   = -diff_x;
    neg_y   = -diff_y;
    dx      = diff_x[16] ? neg_x[15:0] : diff_x[15:0];
    dy      = diff_y[16] ? neg_y[15:0] : diff_y[15:0];
    hit_row = (s1.y[15:0] == active_xy[15:0])
              && (dx >= GAP_W) && (dx <= ARM_W);
    hit_col = (s1.x[15:0] == active_xy[31:16])
              && (dy >= GAP_W) && (dy <= ARM_W);
    show    = s1.ov && s1.en && (stale_cnt < STALE_MAX)
              && (hit_row || hit_col);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_data <= '0;
      out_x    <= '0;
      out_y    <= '0;
      out_en   <= 1'b0;
    end else begin
      out_data <= show ? marker_color : s1.data;
      out_x    <= s1.x;
      out_y    <= s1.y;
      out_en   <= s1.en;
    end
  end

endmodule

// File: tb/tb_lazer_marker_overlay.sv
// Bench for lazer_marker_overlay: random pixels and detections
// against a frame-level reference model, plus marker pixel counts.
module tb_lazer_marker_overlay;

  localparam int ARM = 8;
  localparam int GP  = 2;
  localparam int STF = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [31:0] x;
  logic [31:0] y;
  logic [23:0] data;
  logic [31:0] laser_xy;
  logic        laser_valid;
  logic        overlay_en;
  logic [23:0] marker_color;
  logic [23:0] out_data;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic        out_en;

  lazer_marker_overlay dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .x            (x),
    .y            (y),
    .data         (data),
    .laser_xy     (laser_xy),
    .laser_valid  (laser_valid),
    .overlay_en   (overlay_en),
    .marker_color (marker_color),
    .out_data     (out_data),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_en       (out_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d;
    logic [31:0] x;
    logic [31:0] y;
    logic        e;
  } exp_t;

  exp_t        q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          frame_hits;

  // Reference: coordinate latched at each frame start;
  // shown while fewer than STF frame starts passed without news.
  logic [31:0] m_pend;
  logic [31:0] m_act;
  bit          m_fresh;
  int          m_quiet;

  function automatic bit on_marker(int xs, int ys, int lx, int ly);
    int ddx;
    int ddy;
    ddx = (xs > lx) ? xs - lx : lx - xs;
    ddy = (ys > ly) ? ys - ly : ly - ys;
    return (ys == ly && ddx >= GP && ddx <= ARM)
        || (xs == lx && ddy >= GP && ddy <= ARM);
  endfunction

  task automatic step(input logic rn, input logic e,
                      input logic [31:0] xi, input logic [31:0] yi,
                      input logic [23:0] d, input logic lv,
                      input logic [31:0] lxy, input logic oe);
    exp_t ex;
    exp_t got;
    bit   fs;
    reset_n     = rn;
    en          = e;
    x           = xi;
    y           = yi;
    data        = d;
    laser_valid = lv;
    laser_xy    = lxy;
    overlay_en  = oe;
    if (!rn) begin
      m_pend  = '0;
      m_act   = '0;
      m_fresh = 0;
      m_quiet = STF;
      q.delete();
      ex = '{d: '0, x: '0, y: '0, e: 1'b0};
      q.push_back(ex);
      q.push_back(ex);
    end else begin
      fs = e && xi[15:0] == 0 && yi[15:0] == 0;
      if (fs) begin
        m_act   = lv ? lxy : m_pend;
        m_quiet = (m_fresh || lv) ? 0
                : (m_quiet >= STF ? STF : m_quiet + 1);
        m_fresh = 0;
      end
      if (lv) begin
        m_pend = lxy;
        if (!fs) m_fresh = 1;
      end
      ex.x = xi;
      ex.y = yi;
      ex.e = e;
      ex.d = d;
      if (oe && e && m_quiet < STF
          && on_marker(int'(xi[15:0]), int'(yi[15:0]),
                       int'(m_act[31:16]), int'(m_act[15:0])))
        ex.d = marker_color;
      q.push_back(ex);
    end
    @(posedge clk);
    #1;
    got = q.pop_front();
    n_vec++;
    assert (out_data === got.d) else begin
      n_fail++;
      $error("FAIL data x=%0d y=%0d got %h want %h",
             got.x, got.y, out_data, got.d);
    end
    n_vec++;
    assert (out_x === got.x && out_y === got.y) else begin
      n_fail++;
      $error("FAIL xy got %0d,%0d want %0d,%0d",
             out_x, out_y, got.x, got.y);
    end
    n_vec++;
    assert (out_en === got.e) else begin
      n_fail++;
      $error("FAIL en got %b want %b", out_en, got.e);
    end
    if (out_en === 1'b1 && out_data === marker_color)
      frame_hits++;
  endtask

  task automatic gap_step(input logic oe);
    step(1'b1, 1'b0, $urandom, $urandom, 24'($urandom) & 24'h7fffff,
         1'b0, $urandom, oe);
  endtask

  // 32x16 frame; vpix = pixel index pulsing laser_valid,
  // rpix = pixel index where reset_n drops for one cycle.
  task automatic run_frame(input int vpix, input logic [31:0] vxy,
                           input logic oe, input int rpix);
    frame_hits = 0;
    for (int i = 0; i < 512; i++) begin
      if (i != 0 && $urandom_range(0, 15) == 0)
        gap_step(oe);
      step((i == rpix) ? 1'b0 : 1'b1, 1'b1,
           32'(i % 32), 32'(i / 32),
           24'($urandom) & 24'h7fffff,
           (i == vpix), (i == vpix) ? vxy : $urandom, oe);
    end
    for (int i = 0; i < 4; i++)
      gap_step(oe);
  endtask

  task automatic check_hits(input string tag, input int want);
    n_vec++;
    assert (frame_hits == want) else begin
      n_fail++;
      $error("FAIL %s marker pixels got %0d want %0d",
             tag, frame_hits, want);
    end
  endtask

  initial begin
    marker_color = 24'hff00ff;
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'd0, 32'd0, 24'h123456, 1'b1,
           32'h00050005, 1'b1);
    gap_step(1'b1);

    run_frame(-1, '0, 1'b1, -1);
    check_hits("no_detect", 0);
    run_frame(200, {16'd10, 16'd5}, 1'b1, -1);
    check_hits("frame0", 0);
    run_frame(300, {16'd20, 16'd9}, 1'b1, -1);
    check_hits("frame1", 25);
    run_frame(-1, '0, 1'b1, -1);
    check_hits("frame2", 26);
    run_frame(-1, '0, 1'b1, -1);
    run_frame(-1, '0, 1'b1, -1);
    run_frame(-1, '0, 1'b1, -1);
    check_hits("stale_last", 26);
    run_frame(-1, '0, 1'b1, -1);
    check_hits("stale_off", 0);
    run_frame(0, {16'd0, 16'd0}, 1'b1, -1);
    check_hits("fs_bypass", 14);
    run_frame(-1, '0, 1'b0, -1);
    check_hits("overlay_off", 0);
    run_frame(-1, '0, 1'b1, 200);
    run_frame(-1, '0, 1'b1, -1);
    check_hits("after_reset", 0);
    run_frame(100, {16'd5, 16'd12}, 1'b1, -1);
    check_hits("pre_marker", 0);
    run_frame(-1, '0, 1'b1, -1);
    check_hits("clipped", 20);

    for (int f = 0; f < 4; f++)
      run_frame($urandom_range(0, 511),
                {16'($urandom_range(0, 40)),
                 16'($urandom_range(0, 20))},
                1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end

endmodule
